// File: rtl/mac_pe.sv
// rtl/mac_pe.sv - output-stationary MAC processing element; optional saturation via MAC_PE_SAT_EN
module mac_pe #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 32,
    parameter int MUL_STAGES = 2,
    parameter int SIGNED     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic              a_last_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic              a_last_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  c_out,
    output logic              c_vld,
    output logic              c_ovf
);

    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_vld;
    logic              r_last;

    logic signed [PW-1:0] w_a_x;
    logic signed [PW-1:0] w_b_x;
    logic [PW-1:0]        w_prod;

    logic [PW-1:0]         r_p [MUL_STAGES];
    logic [MUL_STAGES-1:0] r_pv;
    logic [MUL_STAGES-1:0] r_pl;

    logic [PW-1:0]    w_p_t;
    logic             w_tv;
    logic             w_tl;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_sum;

    logic [ACC_W-1:0] r_acc;
    logic             r_empty;
    logic [ACC_W-1:0] r_c;
    logic             r_cv;

    // Input stage: these registers double as the east/south forwarding outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else if (en) begin
            r_a    <= a_in;
            r_b    <= b_in;
            r_vld  <= a_vld_in;
            r_last <= a_last_in;
        end
    end

    assign a_out      = r_a;
    assign b_out      = r_b;
    assign a_vld_out  = r_vld;
    assign a_last_out = r_last;

    // Operands are widened to the full product width first so the low PW bits
    // of the multiply are correct for either signedness.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a_x   = PW'($signed(r_a));
            assign w_b_x   = PW'($signed(r_b));
            assign w_p_ext = ACC_W'($signed(w_p_t));
        end else begin : g_unsigned
            assign w_a_x   = PW'(r_a);
            assign w_b_x   = PW'(r_b);
            assign w_p_ext = ACC_W'(w_p_t);
        end
    endgenerate

    assign w_prod = w_a_x * w_b_x;

    // Multiplier pipeline: product travels with its valid tag and a last tag
    // that is only set for valid pairs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
            r_pl <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_p[i] <= '0;
            end
        end else if (en) begin
            r_p[0]  <= w_prod;
            r_pv[0] <= r_vld;
            r_pl[0] <= r_vld & r_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_p[i]  <= r_p[i-1];
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
            end
        end
    end

    assign w_p_t = r_p[MUL_STAGES-1];
    assign w_tv  = r_pv[MUL_STAGES-1];
    assign w_tl  = r_pl[MUL_STAGES-1];

    // An empty accumulator adds to zero, which loads the first product directly
    assign w_base = r_empty ? '0 : r_acc;

`ifdef MAC_PE_SAT_EN
    logic [ACC_W:0] w_sum_x;
    logic           w_clamp;
    logic           r_sticky;
    logic           r_ovf;

    // Widened add, then clamp to the representable range on overflow
    always_comb begin
        w_sum_x = '0;
        w_clamp = 1'b0;
        w_sum   = '0;
        if (SIGNED != 0) begin
            w_sum_x = {w_base[ACC_W-1], w_base} + {w_p_ext[ACC_W-1], w_p_ext};
            w_clamp = w_sum_x[ACC_W] ^ w_sum_x[ACC_W-1];
            if (!w_clamp) begin
                w_sum = w_sum_x[ACC_W-1:0];
            end else if (w_sum_x[ACC_W]) begin
                w_sum = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_sum = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            w_sum_x = {1'b0, w_base} + {1'b0, w_p_ext};
            w_clamp = w_sum_x[ACC_W];
            w_sum   = w_clamp ? '1 : w_sum_x[ACC_W-1:0];
        end
    end

    // Sticky clamp flag per stream, published with the result and cleared with empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (en && w_tv) begin
            r_sticky <= w_tl ? 1'b0 : (r_sticky | w_clamp);
            if (w_tl) begin
                r_ovf <= r_sticky | w_clamp;
            end
        end
    end

    assign c_ovf = r_ovf;
`else
    assign w_sum = w_base + w_p_ext;
    assign c_ovf = 1'b0;
`endif

    // Accumulator tail: a last-tagged product publishes the sum and re-arms empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_empty <= 1'b1;
            r_c     <= '0;
            r_cv    <= 1'b0;
        end else if (en) begin
            r_cv <= w_tv & w_tl;
            if (w_tv) begin
                r_acc   <= w_sum;
                r_empty <= w_tl;
                if (w_tl) begin
                    r_c <= w_sum;
                end
            end
        end
    end

    assign c_out = r_c;
    assign c_vld = r_cv;

endmodule

// File: tb/tb_mac_pe.sv
// tb/tb_mac_pe.sv - self-checking bench for mac_pe across three parameter sets
module tb_mac_pe;

`ifdef MAC_PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       a_vld_in;
    logic       a_last_in;

    logic [7:0]  a_out0, b_out0, a_out1, b_out1, a_out2, b_out2;
    logic        av0, al0, av1, al1, av2, al2;
    logic [31:0] c_out0;
    logic [15:0] c_out1, c_out2;
    logic        cv0, cv1, cv2, co0, co1, co2;

    always #5 clk = ~clk;

    mac_pe u0 (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
        .b_in(b_in), .a_out(a_out0), .a_vld_out(av0), .a_last_out(al0), .b_out(b_out0),
        .c_out(c_out0), .c_vld(cv0), .c_ovf(co0)
    );

    mac_pe #(.DATA_W(8), .ACC_W(16), .MUL_STAGES(3), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
        .b_in(b_in), .a_out(a_out1), .a_vld_out(av1), .a_last_out(al1), .b_out(b_out1),
        .c_out(c_out1), .c_vld(cv1), .c_ovf(co1)
    );

    mac_pe #(.DATA_W(8), .ACC_W(16), .MUL_STAGES(1), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .a_vld_in(a_vld_in), .a_last_in(a_last_in),
        .b_in(b_in), .a_out(a_out2), .a_vld_out(av2), .a_last_out(al2), .b_out(b_out2),
        .c_out(c_out2), .c_vld(cv2), .c_ovf(co2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ecnt  = 0;
    bit last_en_edge;

    // reference model state
    logic [7:0] e_a, e_b;
    bit         e_v, e_l;
    bit         e_cv [3];
    longint     e_c  [3];
    bit         e_ov [3];
    longint     acc_s [3];
    bit         emp [3];
    bit         stk [3];
    int         dq [3][16];
    longint     vq [3][16];
    bit         oq [3][16];
    int         hd [3];
    int         tl [3];

    // observed result log for directed checks
    longint res_v [3][8];
    bit     res_o [3][8];
    int     res_t [3][8];
    int     res_n [3];

    function automatic int accw(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic bit sgn(int d);
        return (d != 2);
    endfunction

    function automatic int mstages(int d);
        return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
    endfunction

    function automatic longint prod(int d, logic [7:0] a, logic [7:0] b);
        longint x = a;
        longint y = b;
        if (sgn(d)) begin
            if (a[7]) x -= 256;
            if (b[7]) y -= 256;
        end
        return x * y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        longint p, s, smax, smin, msk;
        last_en_edge = 1'b0;
        if (rst) begin
            e_a = '0; e_b = '0; e_v = 1'b0; e_l = 1'b0;
            for (int d = 0; d < 3; d++) begin
                emp[d] = 1'b1; stk[d] = 1'b0; hd[d] = 0; tl[d] = 0;
                e_cv[d] = 1'b0; e_c[d] = 0; e_ov[d] = 1'b0; acc_s[d] = 0;
            end
        end else if (en) begin
            last_en_edge = 1'b1;
            ecnt++;
            e_a = a_in; e_b = b_in; e_v = a_vld_in; e_l = a_last_in;
            for (int d = 0; d < 3; d++) begin
                msk  = (longint'(1) << accw(d)) - 1;
                smax = sgn(d) ? (longint'(1) << (accw(d) - 1)) - 1 : msk;
                smin = sgn(d) ? -(longint'(1) << (accw(d) - 1)) : 0;
                if (a_vld_in) begin
                    p = prod(d, a_in, b_in);
                    s = emp[d] ? p : acc_s[d] + p;
                    if (SAT) begin
                        if (s > smax) begin s = smax; stk[d] = 1'b1; end
                        else if (s < smin) begin s = smin; stk[d] = 1'b1; end
                    end
                    acc_s[d] = s;
                    emp[d]   = 1'b0;
                    if (a_last_in) begin
                        dq[d][tl[d] % 16] = ecnt + 1 + mstages(d);
                        vq[d][tl[d] % 16] = s & msk;
                        oq[d][tl[d] % 16] = stk[d];
                        tl[d]++;
                        emp[d] = 1'b1;
                        stk[d] = 1'b0;
                    end
                end
                if (hd[d] != tl[d] && dq[d][hd[d] % 16] == ecnt) begin
                    e_cv[d] = 1'b1;
                    e_c[d]  = vq[d][hd[d] % 16];
                    e_ov[d] = oq[d][hd[d] % 16];
                    hd[d]++;
                end else begin
                    e_cv[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [63:0] oc [3];
        logic [7:0]  oa [3];
        logic [7:0]  ob [3];
        logic        ov [3], ol [3], ocv [3], oov [3];
        oc[0] = 64'(c_out0); oc[1] = 64'(c_out1); oc[2] = 64'(c_out2);
        oa[0] = a_out0; oa[1] = a_out1; oa[2] = a_out2;
        ob[0] = b_out0; ob[1] = b_out1; ob[2] = b_out2;
        ov[0] = av0; ov[1] = av1; ov[2] = av2;
        ol[0] = al0; ol[1] = al1; ol[2] = al2;
        ocv[0] = cv0; ocv[1] = cv1; ocv[2] = cv2;
        oov[0] = co0; oov[1] = co1; oov[2] = co2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("a_out%0d@%0d", d, cyc), 64'(oa[d]), 64'(e_a));
            chk($sformatf("b_out%0d@%0d", d, cyc), 64'(ob[d]), 64'(e_b));
            chk($sformatf("a_vld_out%0d@%0d", d, cyc), 64'(ov[d]), 64'(e_v));
            chk($sformatf("a_last_out%0d@%0d", d, cyc), 64'(ol[d]), 64'(e_l));
            chk($sformatf("c_vld%0d@%0d", d, cyc), 64'(ocv[d]), 64'(e_cv[d]));
            chk($sformatf("c_out%0d@%0d", d, cyc), oc[d], 64'(e_c[d]));
            if (e_cv[d]) chk($sformatf("c_ovf%0d@%0d", d, cyc), 64'(oov[d]), 64'(e_ov[d]));
            if (last_en_edge && ocv[d] === 1'b1 && res_n[d] < 8) begin
                res_v[d][res_n[d]] = longint'(oc[d]);
                res_o[d][res_n[d]] = oov[d];
                res_t[d][res_n[d]] = cyc;
                res_n[d]++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b, input bit v, input bit l);
        a_in = a; b_in = b; a_vld_in = v; a_last_in = l;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pair(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic clr();
        for (int d = 0; d < 3; d++) res_n[d] = 0;
    endtask

    int t_last;

    initial begin
        rst = 1'b1; en = 1'b1; a_in = 8'h5A; b_in = 8'hA5; a_vld_in = 1'b1; a_last_in = 1'b1;
        for (int d = 0; d < 3; d++) res_n[d] = 0;
        tick();
        tick();
        rst = 1'b0;
        idle(2);

        // dot product (3,4),(-2,5),(7,7) -> 51, 3 cycles after the last pair is sampled
        clr();
        pair(8'd3, 8'd4, 1'b1, 1'b0);
        pair(8'hFE, 8'd5, 1'b1, 1'b0);
        pair(8'd7, 8'd7, 1'b1, 1'b1);
        t_last = cyc;
        idle(6);
        chk("s1_count", 64'(res_n[0]), 64'd1);
        chk("s1_value", 64'(res_v[0][0]), 64'd51);
        chk("s1_latency", 64'(res_t[0][0] - t_last), 64'd3);
        chk("s1_value_u1", 64'(res_v[1][0]), 64'd51);

        // back-to-back streams with no bubble
        clr();
        pair(8'd1, 8'd1, 1'b1, 1'b1);
        pair(8'd2, 8'd3, 1'b1, 1'b0);
        pair(8'd4, 8'd5, 1'b1, 1'b1);
        idle(6);
        chk("s2_count", 64'(res_n[0]), 64'd2);
        chk("s2_first", 64'(res_v[0][0]), 64'd1);
        chk("s2_second", 64'(res_v[0][1]), 64'd26);
        chk("s2_spacing", 64'(res_t[0][1] - res_t[0][0]), 64'd2);

        // 16-bit signed overflow: clamp or wrap depending on build
        clr();
        pair(8'd127, 8'd127, 1'b1, 1'b0);
        pair(8'd127, 8'd127, 1'b1, 1'b0);
        pair(8'd127, 8'd127, 1'b1, 1'b1);
        idle(6);
        chk("s3_value_u1", 64'(res_v[1][0]), SAT ? 64'h7FFF : 64'hBD03);
        chk("s3_ovf_u1", 64'(res_o[1][0]), 64'(SAT));
        chk("s3_value_u0", 64'(res_v[0][0]), 64'd48387);

        // unsigned max product with invalid pairs carrying last around it
        clr();
        pair(8'd9, 8'd9, 1'b0, 1'b1);
        pair(8'd255, 8'd255, 1'b1, 1'b1);
        pair(8'd5, 8'd6, 1'b0, 1'b1);
        idle(6);
        chk("s4_count_u2", 64'(res_n[2]), 64'd1);
        chk("s4_value_u2", 64'(res_v[2][0]), 64'd65025);

        // en dropped for 3 cycles while the result is in flight
        clr();
        pair(8'd2, 8'd2, 1'b1, 1'b0);
        pair(8'd3, 8'd3, 1'b1, 1'b1);
        t_last = cyc;
        idle(1);
        en = 1'b0;
        idle(3);
        en = 1'b1;
        idle(6);
        chk("s5_count", 64'(res_n[0]), 64'd1);
        chk("s5_value", 64'(res_v[0][0]), 64'd13);
        chk("s5_latency", 64'(res_t[0][0] - t_last), 64'd6);

        // reset interrupts a stream
        clr();
        pair(8'd9, 8'd9, 1'b1, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        pair(8'd1, 8'd1, 1'b1, 1'b1);
        idle(6);
        chk("s6_count", 64'(res_n[0]), 64'd1);
        chk("s6_value", 64'(res_v[0][0]), 64'd1);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom % 5) != 0;
            rst = ($urandom % 80) == 0;
            pair(8'($urandom), 8'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0);
        end
        rst = 1'b0;
        en  = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
